mips_controller: RTL and testbench

- Moore-style multicycle control FSM for the 8-bit MIPS core.
- Sits directly upstream of the datapath. It drives every datapath control strobe and consumes the datapath's opcode/funct fields and ALU zero flag.
- Fetches each 32-bit instruction as four bytes over four cycles, then sequences decode, execute, memory and writeback for LB, SB, R-type, BEQ and J.

---
 rtl/mips_pkg.sv | 59 +++++
 rtl/mips_controller_aludec.sv | 30 +++
 rtl/mips_controller.sv | 143 ++++++++++++++
 tb/tb_mips_controller.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - state, opcode, funct, ALU and mux-select encodings for the multicycle MIPS controller
package mips_pkg;

  typedef enum logic [3:0] {
    S_FETCH1  = 4'd0,
    S_FETCH2  = 4'd1,
    S_FETCH3  = 4'd2,
    S_FETCH4  = 4'd3,
    S_DECODE  = 4'd4,
    S_MEMADR  = 4'd5,
    S_LBRD    = 4'd6,
    S_LBWR    = 4'd7,
    S_SBWR    = 4'd8,
    S_RTYPEEX = 4'd9,
    S_RTYPEWR = 4'd10,
    S_BEQEX   = 4'd11,
    S_JEX     = 4'd12,
    S_ADDIEX  = 4'd13,
    S_ADDIWR  = 4'd14
  } state_t;

  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_OFF = 3'b000;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // ALU request from the FSM; NONE keeps alucontrol at 000 in idle states
  typedef enum logic [1:0] {
    ALUOP_NONE  = 2'b00,
    ALUOP_ADD   = 2'b01,
    ALUOP_SUB   = 2'b10,
    ALUOP_FUNCT = 2'b11
  } aluop_t;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_ONE   = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_controller_aludec.sv
// rtl/mips_controller_aludec.sv - resolves the FSM's ALU request and funct into alucontrol
module mips_aludec
  import mips_pkg::*;
(
  input  aluop_t     aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol
);

  always_comb begin
    alucontrol = ALU_OFF;
    case (aluop)
      ALUOP_ADD: alucontrol = ALU_ADD;
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  alucontrol = ALU_ADD;
          FN_SUB:  alucontrol = ALU_SUB;
          FN_AND:  alucontrol = ALU_AND;
          FN_OR:   alucontrol = ALU_OR;
          FN_SLT:  alucontrol = ALU_SLT;
          // unknown funct still executes and writes back, as an add
          default: alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_OFF;
    endcase
  end

endmodule

// File: rtl/mips_controller.sv
// rtl/mips_controller.sv - Moore multicycle control FSM for the 8-bit MIPS core
// Optional ADDI support (states ADDIEX/ADDIWR) is enabled by defining MIPS_ADDI_EN.
module mips_controller
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       memwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic       iord,
  output logic       memtoreg,
  output logic       regdst,
  output logic       regwrite,
  output logic [3:0] irwrite,
  output logic       pcen,
  output logic [2:0] alucontrol,
  output logic [3:0] state
);

  state_t state_q, state_d;
  logic   pcwrite, branch;
  aluop_t aluop;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH1;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH1;
    case (state_q)
      S_FETCH1: state_d = S_FETCH2;
      S_FETCH2: state_d = S_FETCH3;
      S_FETCH3: state_d = S_FETCH4;
      S_FETCH4: state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LB, OP_SB: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTYPEEX;
          OP_BEQ:       state_d = S_BEQEX;
          OP_J:         state_d = S_JEX;
`ifdef MIPS_ADDI_EN
          OP_ADDI:      state_d = S_ADDIEX;
`endif
          default:      state_d = S_FETCH1;
        endcase
      end
      S_MEMADR:  state_d = (op == OP_LB) ? S_LBRD : S_SBWR;
      S_LBRD:    state_d = S_LBWR;
      S_RTYPEEX: state_d = S_RTYPEWR;
`ifdef MIPS_ADDI_EN
      S_ADDIEX:  state_d = S_ADDIWR;
`endif
      default:   state_d = S_FETCH1;
    endcase
  end

  // Reset masks every strobe combinationally, so nothing fires before the FSM settles
  always_comb begin
    memwrite = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = SRCB_B;
    pcsrc    = PC_ALU;
    iord     = 1'b0;
    memtoreg = 1'b0;
    regdst   = 1'b0;
    regwrite = 1'b0;
    irwrite  = 4'b0000;
    pcwrite  = 1'b0;
    branch   = 1'b0;
    aluop    = ALUOP_NONE;
    if (!reset) begin
      case (state_q)
        S_FETCH1, S_FETCH2, S_FETCH3, S_FETCH4: begin
          irwrite = 4'b0001 << state_q[1:0];
          alusrcb = SRCB_ONE;
          aluop   = ALUOP_ADD;
          pcwrite = 1'b1;
        end
        S_DECODE: begin
          alusrcb = SRCB_IMMSH;
          aluop   = ALUOP_ADD;
        end
        S_MEMADR: begin
          alusrca = 1'b1;
          alusrcb = SRCB_IMM;
          aluop   = ALUOP_ADD;
        end
        S_LBRD: iord = 1'b1;
        S_LBWR: begin
          regwrite = 1'b1;
          memtoreg = 1'b1;
        end
        S_SBWR: begin
          iord     = 1'b1;
          memwrite = 1'b1;
        end
        S_RTYPEEX: begin
          alusrca = 1'b1;
          aluop   = ALUOP_FUNCT;
        end
        S_RTYPEWR: begin
          regwrite = 1'b1;
          regdst   = 1'b1;
        end
        S_BEQEX: begin
          alusrca = 1'b1;
          aluop   = ALUOP_SUB;
          pcsrc   = PC_ALUOUT;
          branch  = 1'b1;
        end
        S_JEX: begin
          pcsrc   = PC_JUMP;
          pcwrite = 1'b1;
        end
`ifdef MIPS_ADDI_EN
        S_ADDIEX: begin
          alusrca = 1'b1;
          alusrcb = SRCB_IMM;
          aluop   = ALUOP_ADD;
        end
        S_ADDIWR: regwrite = 1'b1;
`endif
        default: ;
      endcase
    end
  end

  assign pcen  = pcwrite | (branch & zero);
  assign state = reset ? 4'd0 : state_q;

  mips_aludec u_aludec (
    .aluop      (aluop),
    .funct      (funct),
    .alucontrol (alucontrol)
  );

endmodule

// File: tb/tb_mips_controller.sv
// tb/tb_mips_controller.sv - scoreboard bench for mips_controller; ADDI expectations follow MIPS_ADDI_EN
module tb_mips_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] op = 6'd0;
  logic [5:0] funct = 6'd0;
  logic       zero = 1'b0;
  logic       memwrite, alusrca, iord, memtoreg, regdst, regwrite, pcen;
  logic [1:0] alusrcb, pcsrc;
  logic [3:0] irwrite, state;
  logic [2:0] alucontrol;

  always #5 clk = ~clk;

  mips_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .memwrite(memwrite), .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc),
    .iord(iord), .memtoreg(memtoreg), .regdst(regdst), .regwrite(regwrite),
    .irwrite(irwrite), .pcen(pcen), .alucontrol(alucontrol), .state(state)
  );

  // ctl = {memwrite, alusrca, alusrcb, pcsrc, iord, memtoreg, regdst, regwrite, irwrite, pcen, alucontrol}
  localparam logic [17:0] C_ZERO = 18'b0_0_00_00_0_0_0_0_0000_0_000;
  localparam logic [17:0] C_F1   = 18'b0_0_01_00_0_0_0_0_0001_1_010;
  localparam logic [17:0] C_F2   = 18'b0_0_01_00_0_0_0_0_0010_1_010;
  localparam logic [17:0] C_F3   = 18'b0_0_01_00_0_0_0_0_0100_1_010;
  localparam logic [17:0] C_F4   = 18'b0_0_01_00_0_0_0_0_1000_1_010;
  localparam logic [17:0] C_DEC  = 18'b0_0_11_00_0_0_0_0_0000_0_010;
  localparam logic [17:0] C_MADR = 18'b0_1_10_00_0_0_0_0_0000_0_010;
  localparam logic [17:0] C_LBRD = 18'b0_0_00_00_1_0_0_0_0000_0_000;
  localparam logic [17:0] C_LBWR = 18'b0_0_00_00_0_1_0_1_0000_0_000;
  localparam logic [17:0] C_SBWR = 18'b1_0_00_00_1_0_0_0_0000_0_000;
  localparam logic [17:0] C_RSUB = 18'b0_1_00_00_0_0_0_0_0000_0_110;
  localparam logic [17:0] C_ROR  = 18'b0_1_00_00_0_0_0_0_0000_0_001;
  localparam logic [17:0] C_RSLT = 18'b0_1_00_00_0_0_0_0_0000_0_111;
  localparam logic [17:0] C_RUNK = 18'b0_1_00_00_0_0_0_0_0000_0_010;
  localparam logic [17:0] C_RWR  = 18'b0_0_00_00_0_0_1_1_0000_0_000;
  localparam logic [17:0] C_BEQT = 18'b0_1_00_01_0_0_0_0_0000_1_110;
  localparam logic [17:0] C_BEQN = 18'b0_1_00_01_0_0_0_0_0000_0_110;
  localparam logic [17:0] C_JEX  = 18'b0_0_00_10_0_0_0_0_0000_1_000;
  localparam logic [17:0] C_AIEX = 18'b0_1_10_00_0_0_0_0_0000_0_010;
  localparam logic [17:0] C_AIWR = 18'b0_0_00_00_0_0_0_1_0000_0_000;

  typedef struct packed {
    logic [3:0]  st;
    logic [17:0] ctl;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  task automatic step(input logic r, input logic [5:0] o, input logic [5:0] f,
                      input logic z, input logic [3:0] st, input logic [17:0] ctl);
    exp_t e;
    @(posedge clk);
    #1;
    reset = r; op = o; funct = f; zero = z;
    e.st = st; e.ctl = ctl;
    sb_q.push_back(e);
  endtask

  task automatic fetch_decode(input logic [5:0] o, input logic [5:0] f, input logic z);
    step(1'b0, o, f, z, 4'd0, C_F1);
    step(1'b0, o, f, z, 4'd1, C_F2);
    step(1'b0, o, f, z, 4'd2, C_F3);
    step(1'b0, o, f, z, 4'd3, C_F4);
    step(1'b0, o, f, z, 4'd4, C_DEC);
  endtask

  // Monitor: compare DUT outputs against the queued expectation mid-cycle
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      logic [17:0] act;
      e = sb_q.pop_front();
      act = {memwrite, alusrca, alusrcb, pcsrc, iord, memtoreg, regdst, regwrite,
             irwrite, pcen, alucontrol};
      checks++;
      if (state !== e.st || act !== e.ctl) begin
        errors++;
        $display("FAIL cyc%0d state/ctl actual %0d/%b required %0d/%b", cyc, state, act, e.st, e.ctl);
      end
      cyc++;
    end
  end

  initial begin
    // reset held for two edges, then release
    step(1'b1, 6'd0, 6'd0, 1'b0, 4'd0, C_ZERO);
    step(1'b1, 6'd0, 6'd0, 1'b0, 4'd0, C_ZERO);

    // R-type sub
    fetch_decode(6'b000000, 6'b100010, 1'b0);
    step(1'b0, 6'b000000, 6'b100010, 1'b0, 4'd9,  C_RSUB);
    step(1'b0, 6'b000000, 6'b100010, 1'b0, 4'd10, C_RWR);
    // R-type or, slt, unknown funct
    fetch_decode(6'b000000, 6'b100101, 1'b0);
    step(1'b0, 6'b000000, 6'b100101, 1'b0, 4'd9,  C_ROR);
    step(1'b0, 6'b000000, 6'b100101, 1'b0, 4'd10, C_RWR);
    fetch_decode(6'b000000, 6'b101010, 1'b0);
    step(1'b0, 6'b000000, 6'b101010, 1'b0, 4'd9,  C_RSLT);
    step(1'b0, 6'b000000, 6'b101010, 1'b0, 4'd10, C_RWR);
    fetch_decode(6'b000000, 6'b111000, 1'b0);
    step(1'b0, 6'b000000, 6'b111000, 1'b0, 4'd9,  C_RUNK);
    step(1'b0, 6'b000000, 6'b111000, 1'b0, 4'd10, C_RWR);

    // LB
    fetch_decode(6'b100000, 6'd0, 1'b0);
    step(1'b0, 6'b100000, 6'd0, 1'b0, 4'd5, C_MADR);
    step(1'b0, 6'b100000, 6'd0, 1'b0, 4'd6, C_LBRD);
    step(1'b0, 6'b100000, 6'd0, 1'b0, 4'd7, C_LBWR);
    // SB
    fetch_decode(6'b101000, 6'd0, 1'b0);
    step(1'b0, 6'b101000, 6'd0, 1'b0, 4'd5, C_MADR);
    step(1'b0, 6'b101000, 6'd0, 1'b0, 4'd8, C_SBWR);

    // BEQ taken then not taken
    fetch_decode(6'b000100, 6'd0, 1'b1);
    step(1'b0, 6'b000100, 6'd0, 1'b1, 4'd11, C_BEQT);
    fetch_decode(6'b000100, 6'd0, 1'b0);
    step(1'b0, 6'b000100, 6'd0, 1'b0, 4'd11, C_BEQN);

    // J, then an unknown opcode that must do nothing after decode
    fetch_decode(6'b000010, 6'd0, 1'b0);
    step(1'b0, 6'b000010, 6'd0, 1'b0, 4'd12, C_JEX);
    fetch_decode(6'b111111, 6'd0, 1'b0);

    // ADDI opcode
    fetch_decode(6'b001000, 6'd0, 1'b0);
`ifdef MIPS_ADDI_EN
    step(1'b0, 6'b001000, 6'd0, 1'b0, 4'd13, C_AIEX);
    step(1'b0, 6'b001000, 6'd0, 1'b0, 4'd14, C_AIWR);
`endif

    // reset during FETCH3 abandons the instruction
    step(1'b0, 6'b000000, 6'b100000, 1'b0, 4'd0, C_F1);
    step(1'b0, 6'b000000, 6'b100000, 1'b0, 4'd1, C_F2);
    step(1'b1, 6'b000000, 6'b100000, 1'b0, 4'd0, C_ZERO);
    step(1'b0, 6'b000000, 6'b100000, 1'b0, 4'd0, C_F1);
    step(1'b0, 6'b000000, 6'b100000, 1'b0, 4'd1, C_F2);

    @(posedge clk);
    @(posedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending actual %0d required 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
